param_apu: RTL and testbench
============================

PARAM_APU -- requirements
Module: param_apu

Interface
REQ-001 Parameter NCH, default 2: number of upstream read channels, 1..8.
REQ-002 Parameter DW, default 128: data word width, 16..512.
REQ-003 Parameter AW, default 8: address width; frame holds at most 2^AW words.
REQ-004 Parameter DEPTH, default 3: algorithm pipeline register stages, 1..8.
REQ-005 Ports: clk  in  1  sole clock; reset  in  1  synchronous, active-high reset.
REQ-006 Ports: rd_en  out  NCH  per-channel read enable, all bits identical; rd_addr  out  AW  shared read address.
REQ-007 Ports: rd_data  in  NCH*DW  channel c on bits [c*DW +: DW]; valid the cycle after rd_en.
REQ-008 Ports: mode  in  2  combine mode, sampled at frame start.
REQ-009 Ports: rd_EvTID_ready  in  1  upstream frame available; rd_EvTID_DONE  out  1  one-cycle pulse, frame read complete.
REQ-010 Ports: wr_en  out  1; wr_addr  out  AW; wr_data  out  DW  downstream write; wr_EvTID_DONE  out  1  one-cycle pulse, frame written.
REQ-011 Ports: frame_cnt  out  16  completed-write frame counter.

Function
REQ-012 Frame format: word 0 is the header; header[AW-1:0] = L, the last address; body words are addresses 1..L; L=0 means header-only.
REQ-013 Read FSM states: IDLE, HDR, BODY, DONE.
REQ-014 IDLE: when rd_EvTID_ready=1 and not in cooldown, drive rd_en=1 with rd_addr=0 combinationally in the same cycle, latch mode, go to HDR.
REQ-015 HDR: channel 0 rd_data is the header; capture L; if L=0 drive rd_en=0 and go to DONE; otherwise drive rd_en=1 with rd_addr=1 and go to BODY (L=1 goes to DONE).
REQ-016 BODY: drive rd_en=1 every cycle with the address incrementing by 1; after issuing address L go to DONE.
REQ-017 DONE: rd_EvTID_DONE=1 and rd_en=0; go to IDLE; the next IDLE cycle is cooldown, in which rd_EvTID_ready is ignored.
REQ-018 A frame with last address L has L+1 consecutive read cycles; rd_EvTID_DONE pulses exactly 1 cycle after the last read cycle.
REQ-019 Each returned word enters the pipeline with tags first (addr 0) and last (addr L).
REQ-020 Header word passes through unmodified from channel 0.
REQ-021 Body word combine: mode 0 = sum of all NCH channels modulo 2^DW; mode 1 = channel 0 pass-through; mode 2 = bitwise XOR of all channels; mode 3 = bitwise XOR of all channels, same as mode 2.
REQ-022 Latency: a word read in cycle t is written with wr_en=1 in cycle t+1+DEPTH; wr_en is high only for valid pipeline words.
REQ-023 wr_addr is 0 on a first-tagged word and increments by 1 per written word; wr_data is the combined word.
REQ-024 wr_EvTID_DONE pulses exactly 1 cycle after the last-tagged write.
REQ-025 frame_cnt increments on each wr_EvTID_DONE and wraps from 0xFFFF to 0.
REQ-026 Overlap: a new frame may begin reading while the previous frame drains; the tags keep the frames separate; wr_addr restarts at 0 with no gap required.
REQ-027 mode changes mid-frame have no effect until the next IDLE→HDR transition.

Reset
REQ-028 Reset forces: read FSM to IDLE (no cooldown); pipeline valid bits to 0; rd_en, rd_addr, wr_en, wr_addr, wr_data, rd_EvTID_DONE, wr_EvTID_DONE, frame_cnt to 0.
REQ-029 Reset mid-frame aborts both sides with no DONE pulses; reading restarts at address 0 on the first rd_EvTID_ready after reset is released.
REQ-030 Pipeline data registers need not be reset; only the valid and tag bits are reset.

Structure
REQ-031 Package apu_pkg holds the mode enum (MODE_SUM, MODE_PASS, MODE_XOR) and the default parameter constants.
REQ-032 Sub-module apu_combine: combinational NCH-input reduction selected by mode; param_apu instantiates it once ahead of the DEPTH-stage pipeline.

Verification
REQ-033 NCH=2, DEPTH=3, L=4, mode 0, ch0 body words 1..4, ch1 body words 10..40 -> writes at addr 1..4 are 11,22,33,44; first wr_en 4 cycles after first rd_en; rd_DONE at read cycle +5.
REQ-034 L=0 header-only frame -> exactly one read and one write (addr 0, header value); both DONE pulses fire; frame_cnt=1.
REQ-035 rd_EvTID_ready held high -> back-to-back frames L=2 then L=3 with exactly one idle cycle between them; wr_addr sequence 0,1,2,0,1,2,3.
REQ-036 mode 0, ch0=ch1=2^DW-1 -> wr_data = 2^DW-2 (wrap); mode 2 with the same inputs -> 0.
REQ-037 Assert reset at read cycle 2 of an L=5 frame -> no DONE pulses, wr_en stays 0; the next frame reads from address 0 and is written correctly.
REQ-038 Mode toggled from 0 to 1 mid-frame -> the whole frame uses mode 0; the next frame uses mode 1.

Source files
------------

// File: rtl/apu_pkg.sv
// apu_pkg: shared definitions for the param_apu frame processor.
//   - apu_mode_e : body-word combine modes (encoding 3 behaves like MODE_XOR)
//   - Def*       : default values for the param_apu parameters
package apu_pkg;

  typedef enum logic [1:0] {
    MODE_SUM  = 2'd0,
    MODE_PASS = 2'd1,
    MODE_XOR  = 2'd2
  } apu_mode_e;

  localparam int unsigned DefNch   = 2;
  localparam int unsigned DefDw    = 128;
  localparam int unsigned DefAw    = 8;
  localparam int unsigned DefDepth = 3;

endpackage

// File: rtl/apu_combine.sv
// apu_combine: combinational reduction of NCH channel words into one word.
// Ports:
//   mode_i  combine mode (apu_mode_e encoding; 3 is treated as XOR)
//   data_i  NCH packed words, channel c on [c*DW +: DW]
//   data_o  combined word
module apu_combine
  import apu_pkg::*;
#(
  parameter int unsigned NCH = DefNch,
  parameter int unsigned DW  = DefDw
) (
  input  logic [1:0]        mode_i,
  input  logic [NCH*DW-1:0] data_i,
  output logic [DW-1:0]     data_o
);

  logic [DW-1:0] sum;
  logic [DW-1:0] xr;

  always_comb begin
    sum = '0;
    xr  = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      sum = sum + data_i[c*DW +: DW];
      xr  = xr ^ data_i[c*DW +: DW];
    end
  end

  always_comb begin
    case (mode_i)
      MODE_SUM:  data_o = sum;
      MODE_PASS: data_o = data_i[DW-1:0];
      default:   data_o = xr;
    endcase
  end

endmodule

// File: rtl/param_apu.sv
// param_apu: reads header-prefixed frames from NCH upstream channels, combines
// the channels word by word and writes the result downstream through a
// DEPTH-stage pipeline.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   rd_en, rd_addr             upstream read request (all rd_en bits equal)
//   rd_data                    upstream data, valid the cycle after rd_en
//   mode                       combine mode, latched at frame start
//   rd_EvTID_ready             upstream frame available
//   rd_EvTID_DONE              one-cycle pulse after the last read of a frame
//   wr_en, wr_addr, wr_data    downstream write
//   wr_EvTID_DONE              one-cycle pulse after the last write of a frame
//   frame_cnt                  count of completed written frames (wraps)
module param_apu
  import apu_pkg::*;
#(
  parameter int unsigned NCH   = DefNch,
  parameter int unsigned DW    = DefDw,
  parameter int unsigned AW    = DefAw,
  parameter int unsigned DEPTH = DefDepth
) (
  input  logic              clk,
  input  logic              reset,
  output logic [NCH-1:0]    rd_en,
  output logic [AW-1:0]     rd_addr,
  input  logic [NCH*DW-1:0] rd_data,
  input  logic [1:0]        mode,
  input  logic              rd_EvTID_ready,
  output logic              rd_EvTID_DONE,
  output logic              wr_en,
  output logic [AW-1:0]     wr_addr,
  output logic [DW-1:0]     wr_data,
  output logic              wr_EvTID_DONE,
  output logic [15:0]       frame_cnt
);

  typedef enum logic [1:0] {StIdle, StHdr, StBody, StDone} rd_state_e;

  rd_state_e   state_q, state_d;
  logic        cool_q, cool_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] last_q, last_d;
  logic [1:0]  mode_q, mode_d;
  // Tags of the read issued this cycle; they describe rd_data next cycle.
  logic        rv_q, rv_d;
  logic        rfirst_q, rfirst_d;
  logic        rlast_q, rlast_d;

  logic          rd_go;
  logic [AW-1:0] rd_addr_c;
  logic          rd_done;
  logic [AW-1:0] hdr_len;

  assign hdr_len = rd_data[AW-1:0];

  always_comb begin
    state_d   = state_q;
    cool_d    = cool_q;
    addr_d    = addr_q;
    last_d    = last_q;
    mode_d    = mode_q;
    rv_d      = 1'b0;
    rfirst_d  = 1'b0;
    rlast_d   = 1'b0;
    rd_go     = 1'b0;
    rd_addr_c = '0;
    rd_done   = 1'b0;
    case (state_q)
      StIdle: begin
        cool_d = 1'b0;
        if (!cool_q && rd_EvTID_ready) begin
          rd_go    = 1'b1;
          mode_d   = mode;
          rv_d     = 1'b1;
          rfirst_d = 1'b1;
          state_d  = StHdr;
        end
      end
      StHdr: begin
        last_d = hdr_len;
        if (hdr_len == '0) begin
          state_d = StDone;
        end else begin
          rd_go     = 1'b1;
          rd_addr_c = AW'(1);
          addr_d    = AW'(1);
          rv_d      = 1'b1;
          rlast_d   = (hdr_len == AW'(1));
          state_d   = rlast_d ? StDone : StBody;
        end
      end
      StBody: begin
        rd_go     = 1'b1;
        rd_addr_c = addr_q + AW'(1);
        addr_d    = rd_addr_c;
        rv_d      = 1'b1;
        rlast_d   = (rd_addr_c == last_q);
        if (rlast_d) state_d = StDone;
      end
      default: begin
        rd_done = 1'b1;
        cool_d  = 1'b1;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cool_q   <= 1'b0;
      addr_q   <= '0;
      last_q   <= '0;
      mode_q   <= '0;
      rv_q     <= 1'b0;
      rfirst_q <= 1'b0;
      rlast_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cool_q   <= cool_d;
      addr_q   <= addr_d;
      last_q   <= last_d;
      mode_q   <= mode_d;
      rv_q     <= rv_d;
      rfirst_q <= rfirst_d;
      rlast_q  <= rlast_d;
    end
  end

  // Read-side outputs are Mealy; hold them quiet while reset is asserted.
  assign rd_en         = {NCH{rd_go & ~reset}};
  assign rd_addr       = reset ? '0 : rd_addr_c;
  assign rd_EvTID_DONE = rd_done & ~reset;

  // Pipeline entry: the header's last tag is only known once it arrives.
  logic [DW-1:0] comb_data;
  logic          ent_last;
  logic [DW-1:0] ent_data;
  logic [AW-1:0] ent_addr;
  logic [AW-1:0] waddr_q;

  apu_combine #(
    .NCH(NCH),
    .DW (DW)
  ) u_combine (
    .mode_i(mode_q),
    .data_i(rd_data),
    .data_o(comb_data)
  );

  assign ent_last = rfirst_q ? (hdr_len == '0) : rlast_q;
  assign ent_data = rfirst_q ? rd_data[DW-1:0] : comb_data;
  assign ent_addr = rfirst_q ? '0 : waddr_q + AW'(1);

  logic [DEPTH-1:0] pv_q;
  logic [DEPTH-1:0] pl_q;
  logic [DW-1:0]    pd_q [DEPTH];
  logic [AW-1:0]    pa_q [DEPTH];
  logic             wdone_q;
  logic [15:0]      fcnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      pv_q    <= '0;
      pl_q    <= '0;
      waddr_q <= '0;
      wdone_q <= 1'b0;
      fcnt_q  <= '0;
      // Data/address also cleared so the write port reads 0 out of reset.
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pd_q[i] <= '0;
        pa_q[i] <= '0;
      end
    end else begin
      if (rv_q) waddr_q <= ent_addr;
      pv_q[0] <= rv_q;
      pl_q[0] <= rv_q & ent_last;
      pd_q[0] <= ent_data;
      pa_q[0] <= ent_addr;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        pv_q[i] <= pv_q[i-1];
        pl_q[i] <= pl_q[i-1];
        pd_q[i] <= pd_q[i-1];
        pa_q[i] <= pa_q[i-1];
      end
      wdone_q <= pv_q[DEPTH-1] & pl_q[DEPTH-1];
      if (wdone_q) fcnt_q <= fcnt_q + 16'd1;
    end
  end

  assign wr_en         = pv_q[DEPTH-1];
  assign wr_addr       = pa_q[DEPTH-1];
  assign wr_data       = pd_q[DEPTH-1];
  assign wr_EvTID_DONE = wdone_q;
  assign frame_cnt     = fcnt_q;

endmodule

// File: tb/tb_param_apu.sv
// tb_param_apu: directed self-checking bench for param_apu (default parameters).
// An upstream memory model with two banks answers reads; a negedge monitor
// logs reads, writes and DONE pulses, which the directed steps then check.
module tb_param_apu;

  localparam int unsigned NCH = 2;
  localparam int unsigned DW  = 128;
  localparam int unsigned AW  = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [NCH-1:0]    rd_en;
  logic [AW-1:0]     rd_addr;
  logic [NCH*DW-1:0] rd_data = '0;
  logic [1:0]        mode;
  logic              rd_ready;
  logic              rd_done;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic              wr_done;
  logic [15:0]       frame_cnt;

  param_apu #(
    .NCH  (NCH),
    .DW   (DW),
    .AW   (AW),
    .DEPTH(3)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .rd_en         (rd_en),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .mode          (mode),
    .rd_EvTID_ready(rd_ready),
    .rd_EvTID_DONE (rd_done),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .wr_EvTID_DONE (wr_done),
    .frame_cnt     (frame_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Upstream memory: two banks, two channels.
  logic [DW-1:0] m0 [2][16];
  logic [DW-1:0] m1 [2][16];
  int bank = 0;
  always @(posedge clk) begin
    if (rd_en[0]) rd_data <= {m1[bank][rd_addr[3:0]], m0[bank][rd_addr[3:0]]};
  end

  int            rd_cyc[$];
  logic [AW-1:0] rd_adr[$];
  int            wr_cyc[$];
  logic [AW-1:0] wr_adr[$];
  logic [DW-1:0] wr_dat[$];
  int            rdd_cyc[$];
  int            wrd_cyc[$];

  always @(negedge clk) begin
    if (rd_en[0]) begin
      rd_cyc.push_back(cyc);
      rd_adr.push_back(rd_addr);
    end
    if (wr_en) begin
      wr_cyc.push_back(cyc);
      wr_adr.push_back(wr_addr);
      wr_dat.push_back(wr_data);
    end
    if (rd_done) rdd_cyc.push_back(cyc);
    if (wr_done) wrd_cyc.push_back(cyc);
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [AW-1:0] exp_rd[$];
  logic [AW-1:0] exp_adr[$];
  logic [DW-1:0] exp_dat[$];

  task automatic chk_rd(input string tag);
    chk({tag, "_rd_n"}, rd_adr.size(), exp_rd.size());
    for (int i = 0; i < exp_rd.size() && i < rd_adr.size(); i++) begin
      chk({tag, "_rd_addr"}, rd_adr[i], exp_rd[i]);
      chk({tag, "_rd_cyc"}, rd_cyc[i], rd_cyc[0] + i);
    end
  endtask

  task automatic chk_wr(input string tag);
    chk({tag, "_wr_n"}, wr_adr.size(), exp_dat.size());
    for (int i = 0; i < exp_dat.size() && i < wr_adr.size(); i++) begin
      chk({tag, "_wr_addr"}, wr_adr[i], exp_adr[i]);
      chk({tag, "_wr_data"}, wr_dat[i], exp_dat[i]);
    end
  endtask

  task automatic clear_logs();
    rd_cyc.delete(); rd_adr.delete(); wr_cyc.delete(); wr_adr.delete();
    wr_dat.delete(); rdd_cyc.delete(); wrd_cyc.delete();
    exp_rd.delete(); exp_adr.delete(); exp_dat.delete();
  endtask

  task automatic reset_dut();
    @(posedge clk); #1 reset = 1'b1; rd_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    clear_logs();
  endtask

  task automatic start_frame();
    @(posedge clk); #1 rd_ready = 1'b1;
    @(posedge clk); #1 rd_ready = 1'b0;
  endtask

  task automatic wait_rdd(input int n, input int maxc);
    int k = 0;
    while (rdd_cyc.size() < n && k < maxc) begin
      @(posedge clk);
      k++;
    end
    chk("wait_rd_done", rdd_cyc.size(), n);
    #1;
  endtask

  task automatic wait_wrd(input int n, input int maxc);
    int k = 0;
    while (wrd_cyc.size() < n && k < maxc) begin
      @(posedge clk);
      k++;
    end
    chk("wait_wr_done", wrd_cyc.size(), n);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic load(input int b, input int idx, input logic [DW-1:0] d0,
                      input logic [DW-1:0] d1);
    m0[b][idx] = d0;
    m1[b][idx] = d1;
  endtask

  logic [DW-1:0] hdr1;
  logic [DW-1:0] ones;
  logic [DW-1:0] e1 [4];
  logic [DW-1:0] e2 [4];

  initial begin
    reset = 1'b1; rd_ready = 1'b0; mode = 2'd0;
    for (int b = 0; b < 2; b++) for (int i = 0; i < 16; i++) load(b, i, '0, '0);

    // Reset state, with ready asserted during reset.
    repeat (3) @(posedge clk);
    #1 rd_ready = 1'b1;
    @(negedge clk);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_rd_done", rd_done, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_wr_done", wr_done, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    @(posedge clk); #1 rd_ready = 1'b0; reset = 1'b0;
    clear_logs();

    // L=4, mode 0 sum.
    hdr1 = 128'h0000_0000_0000_DEAD_0000_0000_0000_0004;
    load(0, 0, hdr1, 128'h55);
    for (int i = 1; i <= 4; i++) load(0, i, DW'(i), DW'(10 * i));
    start_frame();
    wait_wrd(1, 60);
    exp_rd = '{0, 1, 2, 3, 4};
    chk_rd("l4");
    exp_adr = '{0, 1, 2, 3, 4};
    exp_dat = '{hdr1, 11, 22, 33, 44};
    chk_wr("l4");
    chk("l4_rd_done_n", rdd_cyc.size(), 1);
    if (rdd_cyc.size() > 0 && rd_cyc.size() > 0)
      chk("l4_rd_done_cyc", rdd_cyc[0], rd_cyc[0] + 5);
    if (wr_cyc.size() > 0 && rd_cyc.size() > 0)
      chk("l4_wr_latency", wr_cyc[0], rd_cyc[0] + 4);
    if (wr_cyc.size() == 5) chk("l4_wr_done_cyc", wrd_cyc[0], wr_cyc[4] + 1);
    chk("l4_frame_cnt", frame_cnt, 1);

    // L=0 header-only frame.
    reset_dut();
    load(0, 0, 128'h1234_0000, 128'h99);
    start_frame();
    wait_wrd(1, 60);
    repeat (10) @(posedge clk);
    #1;
    exp_rd = '{0};
    chk_rd("l0");
    exp_adr = '{0};
    exp_dat = '{128'h1234_0000};
    chk_wr("l0");
    chk("l0_rd_done_n", rdd_cyc.size(), 1);
    chk("l0_wr_done_n", wrd_cyc.size(), 1);
    if (wr_cyc.size() > 0) chk("l0_wr_done_cyc", wrd_cyc[0], wr_cyc[0] + 1);
    chk("l0_frame_cnt", frame_cnt, 1);

    // Back-to-back frames with ready held high.
    reset_dut();
    load(0, 0, 2, 0); load(0, 1, 5, 100); load(0, 2, 6, 200);
    load(1, 0, 3, 0); load(1, 1, 7, 1); load(1, 2, 8, 1); load(1, 3, 9, 1);
    bank = 0;
    @(posedge clk); #1 rd_ready = 1'b1;
    wait_rdd(1, 40);
    bank = 1;
    wait_rdd(2, 40);
    rd_ready = 1'b0;
    wait_wrd(2, 60);
    exp_rd = '{0, 1, 2, 0, 1, 2, 3};
    chk("b2b_rd_n", rd_adr.size(), 7);
    for (int i = 0; i < 7 && i < rd_adr.size(); i++) chk("b2b_rd_addr", rd_adr[i], exp_rd[i]);
    if (rd_cyc.size() > 3 && rdd_cyc.size() > 0)
      chk("b2b_gap", rd_cyc[3], rdd_cyc[0] + 2);
    exp_adr = '{0, 1, 2, 0, 1, 2, 3};
    exp_dat = '{2, 105, 206, 3, 8, 9, 10};
    chk_wr("b2b");
    chk("b2b_frame_cnt", frame_cnt, 2);
    bank = 0;

    // All four modes, including the sum wrap.
    reset_dut();
    ones = '1;
    load(0, 0, 2, 0); load(0, 1, ones, ones); load(0, 2, 128'h0F0F, 128'h00FF);
    e1[0] = {{(DW-1){1'b1}}, 1'b0}; e2[0] = 128'h100E;
    e1[1] = ones;                   e2[1] = 128'h0F0F;
    e1[2] = '0;                     e2[2] = 128'h0FF0;
    e1[3] = '0;                     e2[3] = 128'h0FF0;
    for (int m = 0; m < 4; m++) begin
      clear_logs();
      mode = 2'(m);
      start_frame();
      wait_wrd(1, 60);
      exp_adr = '{0, 1, 2};
      exp_dat = '{2, e1[m], e2[m]};
      chk_wr($sformatf("mode%0d", m));
    end
    chk("modes_frame_cnt", frame_cnt, 4);

    // Reset during read cycle 2 of an L=5 frame.
    reset_dut();
    mode = 2'd0;
    load(0, 0, 5, 0);
    for (int i = 1; i <= 5; i++) load(0, i, DW'(i), 0);
    @(posedge clk); #1 rd_ready = 1'b1;
    @(posedge clk); #1 rd_ready = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("abort_rd_n", rd_adr.size(), 2);
    chk("abort_rd_done_n", rdd_cyc.size(), 0);
    chk("abort_wr_n", wr_adr.size(), 0);
    chk("abort_wr_done_n", wrd_cyc.size(), 0);
    chk("abort_frame_cnt", frame_cnt, 0);
    clear_logs();
    start_frame();
    wait_wrd(1, 60);
    exp_rd = '{0, 1, 2, 3, 4, 5};
    chk_rd("after_abort");
    exp_adr = '{0, 1, 2, 3, 4, 5};
    exp_dat = '{5, 1, 2, 3, 4, 5};
    chk_wr("after_abort");
    chk("after_abort_frame_cnt", frame_cnt, 1);

    // Mode change mid-frame takes effect at the next frame.
    reset_dut();
    mode = 2'd0;
    load(0, 0, 3, 0); load(0, 1, 3, 1); load(0, 2, 5, 2); load(0, 3, 7, 4);
    start_frame();
    mode = 2'd1;
    wait_wrd(1, 60);
    exp_adr = '{0, 1, 2, 3};
    exp_dat = '{3, 4, 7, 11};
    chk_wr("toggle_a");
    clear_logs();
    start_frame();
    wait_wrd(1, 60);
    exp_adr = '{0, 1, 2, 3};
    exp_dat = '{3, 3, 5, 7};
    chk_wr("toggle_b");
    chk("toggle_frame_cnt", frame_cnt, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
